// File: rtl/vga_timing_pkg.sv
// Shared types, default 640x480@60 timing and helpers for the VGA raster timing generator.
package vga_timing_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    localparam int unsigned DEF_H_ACTIVE = 640;
    localparam int unsigned DEF_H_FP     = 16;
    localparam int unsigned DEF_H_SYNC   = 96;
    localparam int unsigned DEF_H_BP     = 48;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 10;
    localparam int unsigned DEF_V_SYNC   = 2;
    localparam int unsigned DEF_V_BP     = 33;
    localparam bit          DEF_SYNC_POL = 1'b0;
    localparam int unsigned DEF_CW       = 10;

    // Number of bits needed to hold values 0..v-1.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'(1) << r) < 64'(v)) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-tick input and raster outputs of the VGA timing generator.
interface vga_timing_gen_if
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW = DEF_CW
);
    logic          pix_ce;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic          line_start;
    logic          frame_start;

    modport master (
        output pix_ce,
        input  hsync, vsync, de, x, y, line_start, frame_start
    );

    modport slave (
        input  pix_ce,
        output hsync, vsync, de, x, y, line_start, frame_start
    );
endinterface

// File: rtl/vga_axis_timer.sv
// One raster axis: four-phase FSM with a per-phase down-counter and a position counter.
module vga_axis_timer
    import vga_timing_pkg::*;
#(
    parameter int unsigned CW    = DEF_CW,
    parameter int unsigned TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          step,
    input  logic [CW-1:0] len_active,
    input  logic [CW-1:0] len_front,
    input  logic [CW-1:0] len_sync,
    input  logic [CW-1:0] len_back,
    output phase_t        phase_nxt_c,
    output logic [CW-1:0] pos,
    output logic          wrap_c
);

    phase_t        phase;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [CW-1:0] pos_nxt;

    // Reset parks the axis on the last count of BACK so the first step wraps to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase <= BACK;
            cnt   <= '0;
            pos   <= CW'(TOTAL - 1);
        end else begin
            phase <= phase_nxt_c;
            cnt   <= cnt_nxt;
            pos   <= pos_nxt;
        end
    end

    // phase_nxt_c is the phase the axis occupies after this clock edge.
    always_comb begin
        phase_nxt_c = phase;
        cnt_nxt     = cnt;
        pos_nxt     = pos;
        if (step) begin
            pos_nxt = pos + CW'(1);
            if (cnt == '0) begin
                case (phase)
                    ACTIVE: begin
                        phase_nxt_c = FRONT;
                        cnt_nxt     = len_front - CW'(1);
                    end
                    FRONT: begin
                        phase_nxt_c = SYNC;
                        cnt_nxt     = len_sync - CW'(1);
                    end
                    SYNC: begin
                        phase_nxt_c = BACK;
                        cnt_nxt     = len_back - CW'(1);
                    end
                    BACK: begin
                        phase_nxt_c = ACTIVE;
                        cnt_nxt     = len_active - CW'(1);
                        pos_nxt     = '0;
                    end
                    default: begin
                        phase_nxt_c = ACTIVE;
                        cnt_nxt     = len_active - CW'(1);
                        pos_nxt     = '0;
                    end
                endcase
            end else begin
                cnt_nxt = cnt - CW'(1);
            end
        end
    end

    always_comb begin
        wrap_c = 1'b0;
        if (step && (phase == BACK) && (cnt == '0)) begin
            wrap_c = 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: H/V axis timers plus registered sync, display-enable and strobes.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter bit          SYNC_POL = DEF_SYNC_POL,
    parameter int unsigned CW       = DEF_CW
) (
    input  logic          clk,
    input  logic          rst,
    vga_timing_gen_if.slave bus
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic        SYNC_ON  = SYNC_POL;
    localparam logic        SYNC_OFF = !SYNC_POL;

    if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
        V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_len
        $error("vga_timing_gen: every phase length must be non-zero");
    end

    if (CW < clog2(H_TOTAL) || CW < clog2(V_TOTAL)) begin : g_bad_cw
        $error("vga_timing_gen: CW too narrow for the raster totals");
    end

    phase_t        h_phase_nxt;
    phase_t        v_phase_nxt;
    logic [CW-1:0] h_pos;
    logic [CW-1:0] v_pos;
    logic          h_wrap;
    logic          v_wrap;
    logic          v_step;

    // The vertical axis moves one line each time the horizontal axis wraps.
    assign v_step = bus.pix_ce & h_wrap;

    vga_axis_timer #(
        .CW    (CW),
        .TOTAL (H_TOTAL)
    ) u_h_axis (
        .clk         (clk),
        .rst         (rst),
        .step        (bus.pix_ce),
        .len_active  (CW'(H_ACTIVE)),
        .len_front   (CW'(H_FP)),
        .len_sync    (CW'(H_SYNC)),
        .len_back    (CW'(H_BP)),
        .phase_nxt_c (h_phase_nxt),
        .pos         (h_pos),
        .wrap_c      (h_wrap)
    );

    vga_axis_timer #(
        .CW    (CW),
        .TOTAL (V_TOTAL)
    ) u_v_axis (
        .clk         (clk),
        .rst         (rst),
        .step        (v_step),
        .len_active  (CW'(V_ACTIVE)),
        .len_front   (CW'(V_FP)),
        .len_sync    (CW'(V_SYNC)),
        .len_back    (CW'(V_BP)),
        .phase_nxt_c (v_phase_nxt),
        .pos         (v_pos),
        .wrap_c      (v_wrap)
    );

    // Registered from the next phase so they change on the same edge as x/y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.hsync       <= SYNC_OFF;
            bus.vsync       <= SYNC_OFF;
            bus.de          <= 1'b0;
            bus.line_start  <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            bus.hsync       <= (h_phase_nxt == SYNC) ? SYNC_ON : SYNC_OFF;
            bus.vsync       <= (v_phase_nxt == SYNC) ? SYNC_ON : SYNC_OFF;
            bus.de          <= (h_phase_nxt == ACTIVE) && (v_phase_nxt == ACTIVE);
            bus.line_start  <= h_wrap;
            bus.frame_start <= h_wrap & v_wrap;
        end
    end

    assign bus.x = h_pos;
    assign bus.y = v_pos;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 raster (active-low syncs) and a tiny raster with active-high syncs.
module tb_vga_timing_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_ce;
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_gen_if #(.CW(10)) bus_d ();
    vga_timing_gen_if #(.CW(4))  bus_s ();

    assign bus_d.pix_ce = pix_ce;
    assign bus_s.pix_ce = pix_ce;

    vga_timing_gen u_dut_def (
        .clk (clk),
        .rst (rst),
        .bus (bus_d)
    );

    // Tiny raster: H 8/2/3/2 (total 15), V 6/1/2/2 (total 11), syncs active-high.
    vga_timing_gen #(
        .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (2),
        .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
        .SYNC_POL (1'b1), .CW (4)
    ) u_dut_small (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    task automatic chk(input string tag, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0d expected %0d", tag, idx, got, exp);
        end
    endtask

    task automatic clk_step(input logic ce);
        pix_ce = ce;
        @(negedge clk);
    endtask

    initial begin
        int          xd, yd, xs, ys;
        logic        e_hs, e_vs, e_de;
        int unsigned de_cnt, hs_low, d_fs_cnt;
        int unsigned ls_cyc[$];
        int unsigned fs_cyc[$];

        de_cnt = 0; hs_low = 0; d_fs_cnt = 0;
        rst = 1'b1;
        pix_ce = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Move partway into the first line before the asynchronous reset.
        repeat (37) clk_step(1'b1);
        pix_ce = 1'b0;
        chk("pre_x", 0, 32'(bus_d.x), 32'd36);
        chk("pre_y", 0, 32'(bus_d.y), 32'd0);

        // Reset asserted between clock edges must take effect immediately.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rst_x",   0, 32'(bus_d.x), 32'd799);
        chk("rst_y",   0, 32'(bus_d.y), 32'd524);
        chk("rst_hs",  0, 32'(bus_d.hsync), 32'd1);
        chk("rst_vs",  0, 32'(bus_d.vsync), 32'd1);
        chk("rst_de",  0, 32'(bus_d.de), 32'd0);
        chk("rst_ls",  0, 32'(bus_d.line_start), 32'd0);
        chk("rst_fs",  0, 32'(bus_d.frame_start), 32'd0);
        chk("srst_x",  0, 32'(bus_s.x), 32'd14);
        chk("srst_y",  0, 32'(bus_s.y), 32'd10);
        chk("srst_hs", 0, 32'(bus_s.hsync), 32'd0);
        chk("srst_vs", 0, 32'(bus_s.vsync), 32'd0);
        #1 rst = 1'b0;
        @(negedge clk);

        // Divided pix_ce (1 in 5): one full default line plus the next line start.
        for (int k = 1; k <= 801; k++) begin
            clk_step(1'b1);
            xd = (k - 1) % 800;
            yd = (k - 1) / 800;
            e_hs = !(xd >= 656 && xd <= 751);
            e_vs = !(yd >= 490 && yd <= 491);
            e_de = (xd < 640) && (yd < 480);
            chk("d_x",  k, 32'(bus_d.x), 32'(xd));
            chk("d_y",  k, 32'(bus_d.y), 32'(yd));
            chk("d_hs", k, 32'(bus_d.hsync), 32'(e_hs));
            chk("d_vs", k, 32'(bus_d.vsync), 32'(e_vs));
            chk("d_de", k, 32'(bus_d.de), 32'(e_de));
            chk("d_ls", k, 32'(bus_d.line_start), 32'(xd == 0));
            chk("d_fs", k, 32'(bus_d.frame_start), 32'(xd == 0 && yd == 0));

            xs = (k - 1) % 15;
            ys = ((k - 1) / 15) % 11;
            chk("s_x",  k, 32'(bus_s.x), 32'(xs));
            chk("s_y",  k, 32'(bus_s.y), 32'(ys));
            chk("s_hs", k, 32'(bus_s.hsync), 32'(xs >= 10 && xs <= 12));
            chk("s_vs", k, 32'(bus_s.vsync), 32'(ys >= 7 && ys <= 8));
            chk("s_de", k, 32'(bus_s.de), 32'(xs < 8 && ys < 6));
            chk("s_ls", k, 32'(bus_s.line_start), 32'(xs == 0));
            chk("s_fs", k, 32'(bus_s.frame_start), 32'(xs == 0 && ys == 0));

            if (k <= 800) begin
                if (bus_d.de) de_cnt++;
                if (!bus_d.hsync) hs_low++;
            end
            if (bus_d.frame_start) d_fs_cnt++;
            if (bus_d.line_start) ls_cyc.push_back(cyc);
            if (bus_s.frame_start) fs_cyc.push_back(cyc);

            // Between ticks everything holds and the strobes drop back to 0.
            for (int j = 0; j < 4; j++) begin
                clk_step(1'b0);
                chk("hold", k,
                    32'({bus_d.x, bus_d.y, bus_d.hsync, bus_d.vsync, bus_d.de,
                         bus_d.line_start, bus_d.frame_start}),
                    32'({10'(xd), 10'(yd), e_hs, e_vs, e_de, 2'b00}));
            end
        end

        chk("de_ticks",   0, 32'(de_cnt), 32'd640);
        chk("hs_low",     0, 32'(hs_low), 32'd96);
        chk("d_fs_count", 0, 32'(d_fs_cnt), 32'd1);
        chk("ls_count",   0, 32'(ls_cyc.size()), 32'd2);
        chk("ls_gap",     0, (ls_cyc.size() >= 2) ? 32'(ls_cyc[1] - ls_cyc[0]) : 32'd0, 32'd4000);
        chk("s_fs_count", 0, 32'(fs_cyc.size()), 32'd5);
        for (int i = 1; i < 5; i++) begin
            chk("s_fs_gap", i, (fs_cyc.size() > i) ? 32'(fs_cyc[i] - fs_cyc[i-1]) : 32'd0, 32'd825);
        end

        // Continuous pix_ce must yield the same per-tick sequence as the divided run.
        rst = 1'b1;
        #2 rst = 1'b0;
        @(negedge clk);
        for (int k = 1; k <= 800; k++) begin
            clk_step(1'b1);
            xd = k - 1;
            e_hs = !(xd >= 656 && xd <= 751);
            e_de = xd < 640;
            chk("c_seq", k,
                32'({bus_d.x, bus_d.y, bus_d.hsync, bus_d.vsync, bus_d.de}),
                32'({10'(xd), 10'd0, e_hs, 1'b1, e_de}));
            chk("c_ls", k, 32'(bus_d.line_start), 32'(xd == 0));
        end
        pix_ce = 1'b0;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
